// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit qualification, mid-bit sampling from a
// 16x tick, optional parity, stop check, and a small first-word fall-through FIFO.
module uart_rx_ctrl #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic                 rx,
   input  logic                 rx_enable,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 rd_en,
   input  logic                 err_clr,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rx_valid,
   output logic                 fifo_full,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q;
   logic [BW-1:0]        bit_idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 perr_q, par_en_q, par_odd_q;
   logic                 mid_start, mid_bit, stop_sample, good_stop, bad_stop;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [PW:0]          count_q;
   logic                 push, pop, overrun_set;

   assign mid_start = baud_tick && (cnt_q == CNT_HALF);
   assign mid_bit   = baud_tick && (cnt_q == CNT_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Dropping rx_enable aborts any frame regardless of tick timing.
   always_comb begin
      state_d = state_q;
      if (!rx_enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (baud_tick && !rx) state_d = S_START;
            S_START:  if (mid_start) state_d = rx ? S_IDLE : S_DATA;
            S_DATA:   if (mid_bit && bit_idx_q == LAST_BIT) state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (mid_bit) state_d = S_STOP;
            S_STOP:   if (mid_bit) state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy        = (state_q != S_IDLE);
      stop_sample = (state_q == S_STOP) && mid_bit && rx_enable;
      good_stop   = stop_sample && rx;
      bad_stop    = stop_sample && !rx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         perr_q    <= 1'b0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
      end else if (!rx_enable) begin
         cnt_q     <= '0;
         bit_idx_q <= '0;
      end else if (baud_tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rx) begin
                  cnt_q     <= '0;
                  par_en_q  <= parity_en;
                  par_odd_q <= parity_odd;
                  perr_q    <= 1'b0;
               end
            end
            S_START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_q == CNT_FULL) begin
                  cnt_q     <= '0;
                  shift_q   <= {rx, shift_q[DATA_BITS-1:1]};
                  bit_idx_q <= bit_idx_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_PARITY: begin
               if (cnt_q == CNT_FULL) begin
                  cnt_q  <= '0;
                  perr_q <= rx ^ (^shift_q) ^ par_odd_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt_q == CNT_FULL) cnt_q <= '0;
               else                   cnt_q <= cnt_q + 1'b1;
            end
            default: cnt_q <= '0;
         endcase
      end
   end

   // A pop in the stop-sample cycle frees the slot the new byte lands in.
   assign pop         = rd_en && (count_q != '0);
   assign push        = good_stop && ((count_q != DEPTH_C) || pop);
   assign overrun_set = good_stop && (count_q == DEPTH_C) && !pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         frame_err   <= bad_stop            | (frame_err   & ~err_clr);
         parity_err  <= (push && perr_q)    | (parity_err  & ~err_clr);
         overrun_err <= overrun_set         | (overrun_err & ~err_clr);
      end
   end

   assign rx_valid  = (count_q != '0);
   assign fifo_full = (count_q == DEPTH_C);
   assign rd_data   = rx_valid ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames plus random traffic, checked against
// a frame-level model (byte queue and sticky flag bits).
module tb_uart_rx_ctrl;
   localparam int DB = 8;
   localparam int OS = 16;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          baud_tick = 1'b0;
   logic          rx = 1'b1;
   logic          rx_enable = 1'b0;
   logic          parity_en = 1'b0;
   logic          parity_odd = 1'b0;
   logic          rd_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [DB-1:0] rd_data;
   logic          rx_valid, fifo_full, busy, frame_err, parity_err, overrun_err;

   int            checks = 0;
   int            errors = 0;
   logic [DB-1:0] exp_q[$];
   logic          m_frame = 1'b0, m_parity = 1'b0, m_overrun = 1'b0;
   logic          pop_at_stop = 1'b0, clr_at_stop = 1'b0;

   uart_rx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx), .rx_enable(rx_enable),
      .parity_en(parity_en), .parity_odd(parity_odd), .rd_en(rd_en), .err_clr(err_clr),
      .rd_data(rd_data), .rx_valid(rx_valid), .fifo_full(fifo_full), .busy(busy),
      .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [DB-1:0] head;
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk({tag, " rd_data"}, 32'(rd_data), 32'(head));
      chk({tag, " rx_valid"}, 32'(rx_valid), 32'(exp_q.size() > 0));
      chk({tag, " fifo_full"}, 32'(fifo_full), 32'(exp_q.size() == FD));
      chk({tag, " frame_err"}, 32'(frame_err), 32'(m_frame));
      chk({tag, " parity_err"}, 32'(parity_err), 32'(m_parity));
      chk({tag, " overrun_err"}, 32'(overrun_err), 32'(m_overrun));
   endtask

   // Each tick is high for one posedge, followed by one posedge low.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) baud_tick = 1'b1;
         @(negedge clk) baud_tick = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [DB-1:0] data, input logic pen, input logic podd,
                             input logic flip, input logic stop);
      logic p;
      p = (^data) ^ podd ^ flip;
      parity_en = pen;
      parity_odd = podd;
      rx = 1'b1;
      ticks(2);
      rx = 1'b0;
      ticks(1);
      chk("start busy", 32'(busy), 32'd1);
      ticks(OS - 1);
      // Changes after the start bit must not affect this frame.
      parity_en = 1'($urandom);
      parity_odd = 1'($urandom);
      for (int i = 0; i < DB; i++) begin
         rx = data[i];
         ticks(OS);
      end
      if (pen) begin
         rx = p;
         ticks(OS);
      end
      rx = stop;
      ticks(OS / 2);
      chk("pre-stop busy", 32'(busy), 32'd1);
      check_all("pre-stop");
      @(negedge clk);
      baud_tick = 1'b1;
      rd_en = pop_at_stop;
      err_clr = clr_at_stop;
      @(negedge clk);
      baud_tick = 1'b0;
      rd_en = 1'b0;
      err_clr = 1'b0;
      if (pop_at_stop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (clr_at_stop) begin
         m_frame = 1'b0;
         m_parity = 1'b0;
         m_overrun = 1'b0;
      end
      if (!stop) m_frame = 1'b1;
      else if (exp_q.size() == FD) m_overrun = 1'b1;
      else begin
         exp_q.push_back(data);
         if (pen && flip) m_parity = 1'b1;
      end
      check_all("stop");
      chk("post-stop busy", 32'(busy), 32'd0);
      rx = 1'b1;
      ticks(OS / 2 - 1);
   endtask

   task automatic pop_one();
      @(negedge clk) rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check_all("pop");
   endtask

   task automatic clear_errs();
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      m_frame = 1'b0;
      m_parity = 1'b0;
      m_overrun = 1'b0;
      check_all("clear");
   endtask

   task automatic partial_frame();
      rx = 1'b0;
      ticks(OS);
      rx = 1'b1;
      ticks(2 * OS);
      chk("partial busy", 32'(busy), 32'd1);
   endtask

   initial begin
      ticks(2);
      check_all("reset");
      chk("reset busy", 32'(busy), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      rx_enable = 1'b1;

      // Even parity, clean frame, then pop to empty.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      pop_one();

      // Start glitch shorter than half a bit.
      rx = 1'b0;
      ticks(4);
      rx = 1'b1;
      ticks(4);
      chk("glitch busy mid", 32'(busy), 32'd1);
      ticks(1);
      chk("glitch busy end", 32'(busy), 32'd0);
      check_all("glitch");
      ticks(4);

      // Bad parity is stored and flagged.
      send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
      clear_errs();
      pop_one();

      // Framing error drops the byte; next frame is fine.
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
      pop_one();
      clear_errs();

      // Overrun on the fifth unread byte.
      for (int i = 1; i <= 5; i++) send_frame(DB'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) pop_one();
      clear_errs();

      // Full FIFO with a pop on the stop-sample edge accepts the push.
      for (int i = 0; i < FD; i++) send_frame(DB'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b1);
      pop_at_stop = 1'b1;
      send_frame(8'h77, 1'b1, 1'b1, 1'b0, 1'b1);
      pop_at_stop = 1'b0;
      // Set and clear in the same cycle: set wins.
      clr_at_stop = 1'b1;
      send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
      clr_at_stop = 1'b0;

      // Reset mid-frame empties the FIFO and clears flags.
      partial_frame();
      @(negedge clk) rst_n = 1'b0;
      #1;
      exp_q.delete();
      m_frame = 1'b0;
      m_parity = 1'b0;
      m_overrun = 1'b0;
      check_all("mid reset");
      chk("mid reset busy", 32'(busy), 32'd0);
      rx = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);

      // Disable mid-frame: abort without a tick, FIFO kept.
      partial_frame();
      @(negedge clk) rx_enable = 1'b0;
      @(negedge clk);
      chk("disable busy", 32'(busy), 32'd0);
      check_all("disable");
      rx_enable = 1'b1;
      ticks(2);
      pop_one();

      // Random traffic.
      for (int n = 0; n < 14; n++) begin
         send_frame(DB'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) != 0));
         if (exp_q.size() > 0 && $urandom_range(0, 2) != 0) pop_one();
         if ($urandom_range(0, 3) == 0) clear_errs();
      end
      while (exp_q.size() > 0) pop_one();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
